// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared constants and FSM encoding for the VRAM arbiter
package vram_arb_pkg;
    localparam int REQ_DISP = 0;
    localparam int REQ_CPU  = 1;
    localparam int REQ_REN  = 2;
    localparam int NREQ     = 3;

    localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/vram_rr_pick.sv
// rtl/vram_rr_pick.sv - display-first, CPU/render round-robin one-hot picker
module vram_rr_pick
    import vram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            ptr,   // 1: CPU was granted last, render wins the next tie
    output logic [NREQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[REQ_DISP]) begin
            grant[REQ_DISP] = 1'b1;
        end else if (req[REQ_CPU] && (!req[REQ_REN] || !ptr)) begin
            grant[REQ_CPU] = 1'b1;
        end else if (req[REQ_REN]) begin
            grant[REQ_REN] = 1'b1;
        end
    end

endmodule

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - three-requester VRAM arbiter with ack timeout; perf counters under VRAM_ARB_PERF_EN
module vram_arb
    import vram_arb_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int ADDR_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           req_valid,
    input  logic [2:0]           req_wr,
    input  logic [3*ADDR_W-1:0]  req_addr,
    input  logic [191:0]         req_wdata,
    input  logic [23:0]          req_wmask,
    output logic [2:0]           req_ready,
    output logic [2:0]           resp_valid,
    output logic [63:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 vram_rd,
    output logic                 vram_wr,
    output logic [ADDR_W-1:0]    vram_addr,
    output logic [63:0]          vram_dout,
    output logic [7:0]           vram_wmask,
`ifdef VRAM_ARB_PERF_EN
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_grant2,
    output logic [31:0]          perf_busy,
    output logic [31:0]          perf_timeout,
`endif
    input  logic [63:0]          vram_din,
    input  logic                 vram_ack
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   id_q;
    logic              ptr_q;
    logic              err_q;
    logic [63:0]       rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              tmo_hit;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [63:0]       sel_wdata;
    logic [7:0]        sel_wmask;

    vram_rr_pick u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign tmo_hit    = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign req_ready  = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign resp_valid = (state_q == ST_RESP) ? id_q : '0;
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = rdata_q;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_wr    = req_wr[k];
                sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[k*64 +: 64];
                sel_wmask = req_wmask[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req_valid) state_d = ST_BUSY;
            ST_BUSY: if (vram_ack || tmo_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= '0;
            ptr_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            vram_rd    <= 1'b0;
            vram_wr    <= 1'b0;
            vram_addr  <= '0;
            vram_dout  <= '0;
            vram_wmask <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (|grant) begin
                    id_q       <= grant;
                    err_q      <= 1'b0;
                    cnt_q      <= '0;
                    vram_rd    <= !sel_wr;
                    vram_wr    <= sel_wr;
                    vram_addr  <= sel_addr;
                    vram_dout  <= sel_wdata;
                    vram_wmask <= sel_wmask;
                    // display grants leave the CPU/render fairness untouched
                    if (grant[REQ_CPU])      ptr_q <= 1'b1;
                    else if (grant[REQ_REN]) ptr_q <= 1'b0;
                end
                ST_BUSY: begin
                    if (vram_ack) begin
                        vram_rd <= 1'b0;
                        vram_wr <= 1'b0;
                        rdata_q <= vram_wr ? 64'd0 : vram_din;
                    end else if (tmo_hit) begin
                        vram_rd <= 1'b0;
                        vram_wr <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= ERR_RDATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VRAM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0  <= '0;
            perf_grant1  <= '0;
            perf_grant2  <= '0;
            perf_busy    <= '0;
            perf_timeout <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (grant[REQ_DISP]) perf_grant0 <= perf_grant0 + 1'b1;
                if (grant[REQ_CPU])  perf_grant1 <= perf_grant1 + 1'b1;
                if (grant[REQ_REN])  perf_grant2 <= perf_grant2 + 1'b1;
            end else begin
                perf_busy <= perf_busy + 1'b1;
            end
            if (state_q == ST_BUSY && !vram_ack && tmo_hit)
                perf_timeout <= perf_timeout + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - randomized self-checking bench for vram_arb against a transaction-level model
module tb_vram_arb;
    import vram_arb_pkg::*;

    localparam int TO = 8;
    localparam int AW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req_valid, req_wr, req_ready, resp_valid;
    logic [3*AW-1:0] req_addr;
    logic [191:0]    req_wdata;
    logic [23:0]     req_wmask;
    logic [63:0]     resp_rdata, vram_dout, vram_din;
    logic            resp_err, vram_rd, vram_wr, vram_ack;
    logic [AW-1:0]   vram_addr;
    logic [7:0]      vram_wmask;
`ifdef VRAM_ARB_PERF_EN
    logic [31:0]     perf_grant0, perf_grant1, perf_grant2, perf_busy, perf_timeout;
`endif

    vram_arb #(.ACK_TIMEOUT(TO), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .vram_rd    (vram_rd),
        .vram_wr    (vram_wr),
        .vram_addr  (vram_addr),
        .vram_dout  (vram_dout),
        .vram_wmask (vram_wmask),
`ifdef VRAM_ARB_PERF_EN
        .perf_grant0  (perf_grant0),
        .perf_grant1  (perf_grant1),
        .perf_grant2  (perf_grant2),
        .perf_busy    (perf_busy),
        .perf_timeout (perf_timeout),
`endif
        .vram_din   (vram_din),
        .vram_ack   (vram_ack)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    bit          cpu_last;      // model: CPU was the later of CPU/render grants
    int          m_grant[3];
    int          m_busy;
    int          m_tmo;
    bit          use_fixed = 1'b0;
    logic [63:0] fixed_din = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int model_pick(input logic [2:0] v);
        if (v[0]) return 0;
        if (v[1] && v[2]) return cpu_last ? 2 : 1;
        if (v[1]) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        cpu_last = 1'b0;
        m_busy   = 0;
        m_tmo    = 0;
        for (int k = 0; k < 3; k++) m_grant[k] = 0;
    endtask

    task automatic scramble();
        req_wr = 3'($urandom);
        for (int k = 0; k < 3; k++) begin
            req_addr[k*AW +: AW]  = AW'($urandom);
            req_wdata[k*64 +: 64] = {$urandom, $urandom};
            req_wmask[k*8 +: 8]   = 8'($urandom);
        end
    endtask

    // delay: BUSY cycle index carrying the ack; negative or >= TO means never ack
    task automatic do_txn(input logic [2:0] v, input int delay, input bit fresh);
        int          w, nb;
        bit          tmo;
        logic        e_wr;
        logic [AW-1:0] e_addr;
        logic [63:0] e_data;
        logic [7:0]  e_mask;
        logic [63:0] e_rdata;
        if (fresh) scramble();
        req_valid = v;
        vram_ack  = 1'($urandom);
        w      = model_pick(v);
        e_wr   = req_wr[w];
        e_addr = req_addr[w*AW +: AW];
        e_data = req_wdata[w*64 +: 64];
        e_mask = req_wmask[w*8 +: 8];
        e_rdata = '0;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(3'b001 << w));
        check("resp_idle", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        m_grant[w]++;
        if (w == 1) cpu_last = 1'b1;
        else if (w == 2) cpu_last = 1'b0;
        req_valid = 3'($urandom);
        scramble();
        tmo = !(delay >= 0 && delay < TO);
        nb  = tmo ? TO : delay + 1;
        for (int c = 0; c < nb; c++) begin
            vram_ack = (c == delay);
            vram_din = use_fixed ? fixed_din : {$urandom, $urandom};
            if (c == delay) e_rdata = e_wr ? 64'd0 : vram_din;
            @(negedge clk);
            check("strobe", 64'({vram_wr, vram_rd}), e_wr ? 64'd2 : 64'd1);
            check("ready_busy", 64'(req_ready), 64'd0);
            if (c == 0) begin
                check("vram_addr", 64'(vram_addr), 64'(e_addr));
                check("vram_dout", vram_dout, e_data);
                check("vram_wmask", 64'(vram_wmask), 64'(e_mask));
            end
            @(posedge clk); #1;
        end
        m_busy += nb + 1;
        if (tmo) begin
            m_tmo++;
            e_rdata = ERR_RDATA;
        end
        vram_ack = 1'($urandom);
        vram_din = {$urandom, $urandom};
        @(negedge clk);
        check("resp_valid", 64'(resp_valid), 64'(3'b001 << w));
        check("resp_err", 64'(resp_err), 64'(tmo));
        check("resp_rdata", resp_rdata, e_rdata);
        check("strobe_resp", 64'({vram_wr, vram_rd}), 64'd0);
        check("ready_resp", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        vram_ack  = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog n_chk=%0d expected_end_before_timeout", n_chk);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = 3'b111;
        req_wr = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        vram_din = '0; vram_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_strobes", 64'({vram_wr, vram_rd}), 64'd0);
        check("rst_addr", 64'(vram_addr), 64'd0);
        check("rst_dout", vram_dout, 64'd0);
        check("rst_wmask", 64'(vram_wmask), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // all three at once, immediate ack
        do_txn(3'b111, 0, 1'b1);
        do_txn(3'b110, 0, 1'b1);
        do_txn(3'b100, 0, 1'b1);

        // CPU read with fixed address and data
        scramble();
        req_wr[1] = 1'b0;
        req_addr[AW +: AW] = 24'h000100;
        use_fixed = 1'b1;
        fixed_din = 64'h1122_3344_5566_7788;
        do_txn(3'b010, 3, 1'b0);
        use_fixed = 1'b0;

        // CPU and render contending
        for (int i = 0; i < 6; i++) do_txn(3'b110, int'($urandom_range(0, 3)), 1'b1);

        // render write never acknowledged
        scramble();
        req_wr[2] = 1'b1;
        req_wmask[16 +: 8] = 8'h0F;
        do_txn(3'b100, -1, 1'b0);

        // reset in the middle of a CPU write
        scramble();
        req_wr[1] = 1'b1;
        req_valid = 3'b010;
        @(negedge clk);
        check("mid_rst_ready", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        cpu_last = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_before", 64'(vram_wr), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_wr_after", 64'(vram_wr), 64'd0);
            check("mid_rst_resp", 64'(resp_valid), 64'd0);
        end
        @(posedge clk); #1;
        do_txn(3'b110, 1, 1'b1);

        for (int i = 0; i < 40; i++)
            do_txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 9)), 1'b1);

`ifdef VRAM_ARB_PERF_EN
        @(negedge clk);
        check("perf_grant0", 64'(perf_grant0), 64'(m_grant[0]));
        check("perf_grant1", 64'(perf_grant1), 64'(m_grant[1]));
        check("perf_grant2", 64'(perf_grant2), 64'(m_grant[2]));
        check("perf_busy", 64'(perf_busy), 64'(m_busy));
        check("perf_timeout", 64'(perf_timeout), 64'(m_tmo));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
